// File: rtl/dm_wb_cache_pkg.sv
// Shared types, widths and address-slicing helpers for the direct-mapped write-back cache.
package dm_wb_cache_pkg;

  localparam int ADDR_W     = 30;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int TAG_W      = ADDR_W - OFFSET_W - INDEX_W;
  localparam int NUM_BLOCKS = 2 ** INDEX_W;
  localparam int WORD_W     = 32;
  localparam int BLOCK_W    = 128;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;

  // Controller states: IDLE compares, WB writes the dirty victim back, ALLOC fills the line.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WB    = 2'd1,
    S_ALLOC = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  // Block address seen by memory is the word address without its word-in-block bits.
  function automatic logic [MEM_ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] tag,
                                                       input logic [INDEX_W-1:0] index);
    return {tag, index};
  endfunction

endpackage

// File: rtl/dm_wb_cache_line_array.sv
// Line storage: valid, dirty, tag and 128-bit data per line. Combinational read of the
// addressed line, a per-word write port for write hits and a full-line fill port.
module dm_wb_cache_line_array
  import dm_wb_cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  index,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_data,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] word_sel,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data,
  input  logic                clean_we
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  // Status bits: reset invalidates everything; a fill makes the line valid and clean,
  // a completed write-back cleans it, and a word write marks it dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (clean_we) begin
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bit guards their contents.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[index] <= fill_data;
      tag_q[index]  <= fill_tag;
    end else if (word_we) begin
      data_q[index][WORD_W*int'(word_sel) +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache. Hits complete in the request cycle;
// a miss writes back a dirty victim, fills the line from memory, then re-compares.
module dm_wb_cache
  import dm_wb_cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  state_t state;
  state_t next_state;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic                req;
  logic                hit;

  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;

  logic                word_we;
  logic                fill_we;
  logic                clean_we;

  assign req_tag    = addr_tag(proc_addr);
  assign req_index  = addr_index(proc_addr);
  assign req_offset = addr_offset(proc_addr);
  assign req        = proc_read | proc_write;
  assign hit        = line_valid && (line_tag == req_tag);

  dm_wb_cache_line_array u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (req_index),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .word_we   (word_we),
    .word_sel  (req_offset),
    .word_data (proc_wdata),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_data (mem_rdata),
    .clean_we  (clean_we)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, stall and line-array strobes; mem_ready only matters in WB and ALLOC.
  always_comb begin
    next_state = state;
    proc_stall = 1'b0;
    word_we    = 1'b0;
    fill_we    = 1'b0;
    clean_we   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            word_we = proc_write;
          end else begin
            proc_stall = 1'b1;
            next_state = (line_valid && line_dirty) ? S_WB : S_ALLOC;
          end
        end
      end
      S_WB: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          clean_we   = 1'b1;
          next_state = S_ALLOC;
        end
      end
      S_ALLOC: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          fill_we    = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: begin
        proc_stall = 1'b1;
        next_state = S_IDLE;
      end
    endcase
  end

  // Read data is the addressed word of a hitting line, zero otherwise.
  always_comb begin
    proc_rdata = '0;
    if (state == S_IDLE && proc_read && !proc_write && hit) begin
      proc_rdata = line_data[WORD_W*int'(req_offset) +: WORD_W];
    end
  end

  // Memory request registers follow the state being entered, so they are stable for the
  // whole WB or ALLOC phase and drop as soon as reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (next_state)
        S_WB: begin
          mem_write <= 1'b1;
          mem_read  <= 1'b0;
          if (state == S_IDLE) begin
            mem_addr  <= block_addr(line_tag, req_index);
            mem_wdata <= line_data;
          end
        end
        S_ALLOC: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b1;
          mem_addr  <= block_addr(req_tag, req_index);
        end
        default: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
        end
      endcase
    end
  end

endmodule
